// File: rtl/hazard_sched_ctrl_if.sv
// Decode-stage instruction info flowing into the hazard scheduler, plus the
// stall/flush/forward controls and perf counters it drives back out.
// master: pipeline side (drives decode info), slave: the scheduler.
interface hazard_sched_ctrl_if;
    logic [15:0] instD;
    logic        validD;
    logic        immD;
    logic        regwriteD;
    logic        memreadD;
    logic        branch_takenD;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        forward;
    logic [3:0]  forward_add;
    logic [1:0]  fwdA_E;
    logic [1:0]  fwdB_E;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output instD, validD, immD, regwriteD, memreadD, branch_takenD,
        input  stallF, stallD, flushD, flushE, forward, forward_add,
               fwdA_E, fwdB_E, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  instD, validD, immD, regwriteD, memreadD, branch_takenD,
        output stallF, stallD, flushD, flushE, forward, forward_add,
               fwdA_E, fwdB_E, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Pipeline hazard scheduler for the 16-bit F/D/E/M/W CPU.
// Tracks in-flight destinations in a shadow E/M/W pipeline, detects load-use
// hazards, produces W-stage register-file bypass and E-stage operand forward
// selects, and sequences branch flushes and the HALT drain.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters;
// without it the counter ports read 16'h0 and no counter flops exist.
module hazard_sched_ctrl #(
    parameter logic [3:0] LOAD_OP      = 4'h8,
    parameter logic [3:0] HALT_OP      = 4'hF,
    parameter int         FLUSH_CYCLES = 1
) (
    input logic                 clk,
    input logic                 reset,
    hazard_sched_ctrl_if.slave  hz
);

    // Loads are flagged by memreadD, so LOAD_OP only has to stay distinct
    // from HALT_OP; the flush counter is 3 bits wide.
    if (LOAD_OP == HALT_OP) begin : g_op_check
        $error("LOAD_OP and HALT_OP must differ");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_flush_check
        $error("FLUSH_CYCLES must be in 1..7");
    end

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN, ST_HALTED} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       regwrite;
        logic       memread;
    } shadow_t;

    state_t     state_reg, state_next;
    logic [2:0] flush_left_reg, flush_left_next;
    shadow_t    e_reg, m_reg, w_reg, e_next;
    logic [1:0] fwd_a_reg, fwd_b_reg, fwd_a_next, fwd_b_next;

    logic [3:0] opcode, src1, src2;
    logic       src1_used, src2_used;
    logic       e_match1, e_match2, m_match1, m_match2, w_match1, w_match2;
    logic       load_use, advance;
    logic       stall_f, stall_d, flush_d, flush_e, halted_c;

    assign opcode    = hz.instD[15:12];
    assign src1      = hz.instD[11:8];
    assign src2      = hz.instD[7:4];
    assign src1_used = hz.validD;
    assign src2_used = hz.validD & ~hz.immD;

    // Source-vs-shadow-destination matches for each in-flight stage
    always_comb begin
        e_match1 = src1_used & e_reg.valid & e_reg.regwrite & (e_reg.dest == src1);
        e_match2 = src2_used & e_reg.valid & e_reg.regwrite & (e_reg.dest == src2);
        m_match1 = src1_used & m_reg.valid & m_reg.regwrite & (m_reg.dest == src1);
        m_match2 = src2_used & m_reg.valid & m_reg.regwrite & (m_reg.dest == src2);
        w_match1 = src1_used & w_reg.valid & w_reg.regwrite & (w_reg.dest == src1);
        w_match2 = src2_used & w_reg.valid & w_reg.regwrite & (w_reg.dest == src2);
    end

    assign load_use = e_reg.memread & (e_match1 | e_match2);

    // Operand selects for the instruction entering E: the current E becomes
    // M next cycle (01) and wins over the current M, which becomes W (10).
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (e_match1)      fwd_a_next = 2'b01;
        else if (m_match1) fwd_a_next = 2'b10;
        if (e_match2)      fwd_b_next = 2'b01;
        else if (m_match2) fwd_b_next = 2'b10;
    end

    // Scheduler FSM: next state, flush countdown and control outputs
    always_comb begin
        state_next      = state_reg;
        flush_left_next = flush_left_reg;
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        flush_d         = 1'b0;
        flush_e         = 1'b0;
        halted_c        = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (load_use) begin
                    // Branch in D waits until the stall bubble clears it.
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (hz.validD && hz.branch_takenD) begin
                    flush_d         = 1'b1;
                    flush_left_next = FLUSH_RELOAD;
                    if (FLUSH_RELOAD != 3'd0) state_next = ST_FLUSH;
                end else if (hz.validD && opcode == HALT_OP) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                if (flush_left_reg <= 3'd1) begin
                    flush_left_next = 3'd0;
                    state_next      = ST_RUN;
                end else begin
                    flush_left_next = flush_left_reg - 3'd1;
                end
            end
            ST_DRAIN: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                // E only receives bubbles now, so once E and M are empty the
                // last instruction is retiring from W this cycle.
                if (!e_reg.valid && !m_reg.valid) state_next = ST_HALTED;
            end
            ST_HALTED: begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                halted_c = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign advance = (state_reg == ST_RUN) & ~stall_d & ~flush_d;

    // Shadow entry for the instruction leaving D (bubble when it does not advance)
    always_comb begin
        e_next.valid    = hz.validD & advance;
        e_next.dest     = hz.instD[3:0];
        e_next.regwrite = hz.regwriteD;
        e_next.memread  = hz.memreadD;
    end

    // State, flush counter, shadow pipeline and E-stage forward selects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_RUN;
            flush_left_reg <= 3'd0;
            e_reg          <= '0;
            m_reg          <= '0;
            w_reg          <= '0;
            fwd_a_reg      <= 2'b00;
            fwd_b_reg      <= 2'b00;
        end else begin
            state_reg      <= state_next;
            flush_left_reg <= flush_left_next;
            e_reg          <= e_next;
            m_reg          <= e_reg;
            w_reg          <= m_reg;
            fwd_a_reg      <= e_next.valid ? fwd_a_next : 2'b00;
            fwd_b_reg      <= e_next.valid ? fwd_b_next : 2'b00;
        end
    end

    assign hz.stallF      = stall_f;
    assign hz.stallD      = stall_d;
    assign hz.flushD      = flush_d;
    assign hz.flushE      = flush_e;
    assign hz.halted      = halted_c;
    assign hz.forward     = w_match1 | w_match2;
    assign hz.forward_add = (w_match1 | w_match2) ? w_reg.dest : 4'h0;
    assign hz.fwdA_E      = fwd_a_reg;
    assign hz.fwdB_E      = fwd_b_reg;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_reg, flush_cnt_reg;

    // Saturating counts of load-use stall cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 16'h0;
            flush_cnt_reg <= 16'h0;
        end else begin
            if (load_use && state_reg == ST_RUN && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'h1;
            if (flush_d && flush_cnt_reg != 16'hFFFF)
                flush_cnt_reg <= flush_cnt_reg + 16'h1;
        end
    end

    assign hz.stall_cnt = stall_cnt_reg;
    assign hz.flush_cnt = flush_cnt_reg;
`else
    assign hz.stall_cnt = 16'h0;
    assign hz.flush_cnt = 16'h0;
`endif

endmodule
